// File: rtl/tx_resp_packer.sv
// Serialises ALU results (two bytes, low byte first) and register-file reads (one byte) into FIFO writes.
// Optional build macro RESP_CHECKSUM_EN appends an XOR checksum byte to every response.
module tx_resp_packer #(
   parameter int ALU_DATA_WIDTH = 16,
   parameter int FRAME_WIDTH    = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [ALU_DATA_WIDTH-1:0] ALU_OUT,
   input  logic                      OUT_VALID,
   input  logic [FRAME_WIDTH-1:0]    RdData,
   input  logic                      RdData_Valid,
   input  logic                      FIFO_FULL,
   output logic [FRAME_WIDTH-1:0]    WR_DATA,
   output logic                      WR_INC,
   output logic                      busy,
   output logic                      drop_err
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SEND_LO = 3'd1;
   localparam logic [2:0] ST_SEND_HI = 3'd2;
   localparam logic [2:0] ST_SEND_RD = 3'd3;
`ifdef RESP_CHECKSUM_EN
   localparam logic [2:0] ST_SEND_CHK = 3'd4;
`endif

   localparam int PAD_WIDTH = ALU_DATA_WIDTH - FRAME_WIDTH;

   logic [2:0]                state_r;
   logic [2:0]                next_state_s;
   logic [ALU_DATA_WIDTH-1:0] data_r;
   logic                      drop_err_r;
   logic                      idle_s;
   logic                      busy_s;
   logic                      wr_inc_s;
   logic [FRAME_WIDTH-1:0]    wr_data_s;
   logic                      accept_alu_s;
   logic                      accept_rd_s;
   logic                      drop_s;
`ifdef RESP_CHECKSUM_EN
   logic [FRAME_WIDTH-1:0]    chk_r;

   function automatic logic [FRAME_WIDTH-1:0] chk_fold(
      input logic [FRAME_WIDTH-1:0] acc,
      input logic [FRAME_WIDTH-1:0] frame
   );
      chk_fold = acc ^ frame;
   endfunction
`endif

   // Acceptance and drop decisions for the current cycle's valids
   always_comb begin
      idle_s       = (state_r == ST_IDLE);
      busy_s       = ~idle_s;
      accept_alu_s = idle_s & OUT_VALID;
      accept_rd_s  = idle_s & ~OUT_VALID & RdData_Valid;
      if (idle_s) begin
         drop_s = OUT_VALID & RdData_Valid;
      end else begin
         drop_s = OUT_VALID | RdData_Valid;
      end
   end

   // Byte presented to the FIFO; the write strobe follows FIFO_FULL directly so a full FIFO stalls the same cycle
   always_comb begin
      wr_inc_s = busy_s & ~FIFO_FULL;
      case (state_r)
         ST_SEND_LO: wr_data_s = data_r[FRAME_WIDTH-1:0];
         ST_SEND_HI: wr_data_s = data_r[ALU_DATA_WIDTH-1:FRAME_WIDTH];
         ST_SEND_RD: wr_data_s = data_r[FRAME_WIDTH-1:0];
`ifdef RESP_CHECKSUM_EN
         ST_SEND_CHK: wr_data_s = chk_r;
`endif
         default:    wr_data_s = {FRAME_WIDTH{1'b0}};
      endcase
   end

   // Next-state logic: send states advance only on an accepted write
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (OUT_VALID) begin
               next_state_s = ST_SEND_LO;
            end else if (RdData_Valid) begin
               next_state_s = ST_SEND_RD;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_SEND_LO: begin
            if (wr_inc_s) begin
               next_state_s = ST_SEND_HI;
            end else begin
               next_state_s = state_r;
            end
         end
         ST_SEND_HI, ST_SEND_RD: begin
            if (wr_inc_s) begin
`ifdef RESP_CHECKSUM_EN
               next_state_s = ST_SEND_CHK;
`else
               next_state_s = ST_IDLE;
`endif
            end else begin
               next_state_s = state_r;
            end
         end
`ifdef RESP_CHECKSUM_EN
         ST_SEND_CHK: begin
            if (wr_inc_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = state_r;
            end
         end
`endif
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Captured response payload; register reads are zero-extended into the low byte
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_r <= {ALU_DATA_WIDTH{1'b0}};
      end else if (accept_alu_s) begin
         data_r <= ALU_OUT;
      end else if (accept_rd_s) begin
         data_r <= {{PAD_WIDTH{1'b0}}, RdData};
      end else begin
         data_r <= data_r;
      end
   end

   // Discard indication, one cycle after the offending valid
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         drop_err_r <= 1'b0;
      end else begin
         drop_err_r <= drop_s;
      end
   end

`ifdef RESP_CHECKSUM_EN
   // Running XOR of payload bytes actually written, restarted at each capture
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         chk_r <= {FRAME_WIDTH{1'b0}};
      end else if (accept_alu_s || accept_rd_s) begin
         chk_r <= {FRAME_WIDTH{1'b0}};
      end else if (wr_inc_s && (state_r != ST_SEND_CHK)) begin
         chk_r <= chk_fold(chk_r, wr_data_s);
      end else begin
         chk_r <= chk_r;
      end
   end
`endif

   assign WR_DATA  = wr_data_s;
   assign WR_INC   = wr_inc_s;
   assign busy     = busy_s;
   assign drop_err = drop_err_r;

endmodule

// File: doc/tx_resp_packer.md
TX_RESP_PACKER -- requirements
Module: tx_resp_packer

Interface
REQ-001 SHALL have parameter ALU_DATA_WIDTH, default 16, meaning the ALU result width; it must be 2*FRAME_WIDTH.
REQ-002 SHALL have parameter FRAME_WIDTH, default 8, meaning the width of one register-file/FIFO byte.
REQ-003 SHALL have port CLK  input  1  single clock (reference domain); all state is updated on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ALU_OUT  input  ALU_DATA_WIDTH  ALU result, qualified by OUT_VALID.
REQ-006 SHALL have port OUT_VALID  input  1  single-cycle pulse marking ALU_OUT valid.
REQ-007 SHALL have port RdData  input  FRAME_WIDTH  register-file read data, qualified by RdData_Valid.
REQ-008 SHALL have port RdData_Valid  input  1  single-cycle pulse marking RdData valid.
REQ-009 SHALL have port FIFO_FULL  input  1  async-FIFO write-side full flag.
REQ-010 SHALL have port WR_DATA  output  FRAME_WIDTH  byte presented to the FIFO write port.
REQ-011 SHALL have port WR_INC  output  1  FIFO write strobe; one byte written per high cycle.
REQ-012 SHALL have port busy  output  1  high while a response is being emitted (any state other than IDLE).
REQ-013 SHALL have port drop_err  output  1  registered one-cycle pulse: an input response was discarded.

Function
REQ-014 SHALL implement states IDLE, SEND_LO, SEND_HI, SEND_RD, SEND_CHK.
REQ-015 In IDLE with OUT_VALID=1: SHALL capture ALU_OUT and go to SEND_LO on the next edge.
REQ-016 In IDLE with RdData_Valid=1 and OUT_VALID=0: SHALL capture RdData and go to SEND_RD.
REQ-017 In IDLE with both valids high in the same cycle: the ALU result SHALL be taken, RdData discarded, and drop_err pulsed on the next cycle.
REQ-018 Any valid arriving outside IDLE SHALL be discarded, with drop_err pulsed on the next cycle; the captured data SHALL NOT change.
REQ-019 In a send state, WR_INC SHALL equal !FIFO_FULL (combinational from registered state and FIFO_FULL).
REQ-020 In a send state, WR_DATA SHALL hold the state's byte:
- SEND_LO: captured[7:0]
- SEND_HI: captured[15:8]
- SEND_RD: captured byte
- SEND_CHK: checksum
REQ-021 The state SHALL advance only on a cycle with WR_INC=1; while FIFO_FULL=1 the state and WR_DATA SHALL hold, with no limit on how long.
REQ-022 Transitions SHALL be:
- SEND_LO -> SEND_HI
- SEND_HI -> IDLE, or -> SEND_CHK when the checksum is enabled
- SEND_RD -> IDLE, or -> SEND_CHK when the checksum is enabled
- SEND_CHK -> IDLE
REQ-023 Latency SHALL be: valid at cycle N gives the first WR_INC at cycle N+1 when FIFO_FULL=0.
REQ-024 WR_INC and WR_DATA SHALL be 0 in IDLE.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 A new response SHALL be accepted in the same cycle the FSM is in IDLE, including the cycle immediately after the last byte.
REQ-027 No byte SHALL ever be written twice or skipped.

Reset
REQ-028 RST low SHALL asynchronously force, regardless of any in-progress response:
- state = IDLE
- captured data = 0
- checksum = 0
- WR_INC = 0
- WR_DATA = 0
- busy = 0
- drop_err = 0
REQ-029 After RST deasserts, the first valid SHALL be accepted per REQ-015/016 with no extra wait cycle.

Configuration
REQ-030 Macro RESP_CHECKSUM_EN defined: each response SHALL be followed by one SEND_CHK byte.
- The checksum is the XOR of all payload bytes of that response.
- It is cleared on every capture.
REQ-031 Macro RESP_CHECKSUM_EN undefined: SEND_CHK and the checksum register SHALL NOT exist; responses are 2 bytes (ALU) or 1 byte (register read).

Verification
REQ-032 OUT_VALID=1 with ALU_OUT=16'hA55A and FIFO_FULL=0 SHALL give:
- WR_INC high for 2 consecutive cycles carrying 8'h5A, then 8'hA5.
- With RESP_CHECKSUM_EN, a third cycle carrying 8'hFF.
REQ-033 RdData_Valid=1 with RdData=8'h3C SHALL give:
- One WR_INC carrying 8'h3C.
- With RESP_CHECKSUM_EN, a second byte 8'h3C.
- busy falls afterwards.
REQ-034 ALU_OUT=16'h1234 with FIFO_FULL held high for 5 cycles after capture SHALL give:
- WR_INC=0 and WR_DATA=8'h34 held for those 5 cycles.
- Then 8'h34 and 8'h12 each written exactly once.
REQ-035 OUT_VALID and RdData_Valid in the same cycle (ALU_OUT=16'h00FF, RdData=8'h77) SHALL give:
- Only 8'hFF and 8'h00 written.
- drop_err pulsed once.
REQ-036 RdData_Valid while in SEND_HI SHALL give:
- drop_err pulsed.
- The current response completes unchanged.
REQ-037 RST asserted low mid-response in SEND_HI SHALL give:
- An immediate return to IDLE with all outputs 0.
- The next OUT_VALID after release produces a full 2-byte response.
